// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - TAP state encoding, opcodes, IR capture pattern and next-state function
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR     = 4'hF,
        RTI     = 4'hC,
        SELDR   = 4'h7,
        CAPDR   = 4'h6,
        SHDR    = 4'h2,
        EX1DR   = 4'h1,
        PAUSEDR = 4'h3,
        EX2DR   = 4'h0,
        UPDDR   = 4'h5,
        SELIR   = 4'h4,
        CAPIR   = 4'hE,
        SHIR    = 4'hA,
        EX1IR   = 4'h9,
        PAUSEIR = 4'hB,
        EX2IR   = 4'h8,
        UPDIR   = 4'hD
    } tap_state_t;

    typedef enum logic [1:0] {
        SEL_BYPASS,
        SEL_IDCODE,
        SEL_USER
    } dr_sel_t;

    localparam int unsigned OP_IDCODE  = 1;
    localparam int unsigned OP_USER    = 2;
    localparam logic [1:0]  IR_CAPTURE = 2'b01;

    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        case (s)
            TLR:     return tms ? TLR     : RTI;
            RTI:     return tms ? SELDR   : RTI;
            SELDR:   return tms ? SELIR   : CAPDR;
            CAPDR:   return tms ? EX1DR   : SHDR;
            SHDR:    return tms ? EX1DR   : SHDR;
            EX1DR:   return tms ? UPDDR   : PAUSEDR;
            PAUSEDR: return tms ? EX2DR   : PAUSEDR;
            EX2DR:   return tms ? UPDDR   : SHDR;
            UPDDR:   return tms ? SELDR   : RTI;
            SELIR:   return tms ? TLR     : CAPIR;
            CAPIR:   return tms ? EX1IR   : SHIR;
            SHIR:    return tms ? EX1IR   : SHIR;
            EX1IR:   return tms ? UPDIR   : PAUSEIR;
            PAUSEIR: return tms ? EX2IR   : PAUSEIR;
            EX2IR:   return tms ? UPDIR   : SHIR;
            UPDIR:   return tms ? SELDR   : RTI;
            default: return TLR;
        endcase
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// rtl/jtag_tap_fsm.sv - 16-state TAP controller with registered state-decode strobes
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       trst,
    input  logic       tms,
    output tap_state_t state,
    output logic       tlr,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr,
    output logic       capture_ir,
    output logic       shift_ir,
    output logic       update_ir
);

    tap_state_t nxt;

    always_comb nxt = tap_next(state, tms);

    // strobes are decoded from the next state so they line up with the state register
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            state      <= TLR;
            tlr        <= 1'b1;
            capture_dr <= 1'b0;
            shift_dr   <= 1'b0;
            update_dr  <= 1'b0;
            capture_ir <= 1'b0;
            shift_ir   <= 1'b0;
            update_ir  <= 1'b0;
        end else begin
            state      <= nxt;
            tlr        <= (nxt == TLR);
            capture_dr <= (nxt == CAPDR);
            shift_dr   <= (nxt == SHDR);
            update_dr  <= (nxt == UPDDR);
            capture_ir <= (nxt == CAPIR);
            shift_ir   <= (nxt == SHIR);
            update_ir  <= (nxt == UPDIR);
        end
    end

endmodule

// File: rtl/jtag_tap.sv
// rtl/jtag_tap.sv - JTAG TAP with IR, BYPASS, IDCODE and optional USER DR (JTAG_USERREG_EN)
module jtag_tap
    import jtag_pkg::*;
#(
    parameter int          IR_W   = 4,
    parameter logic [31:0] IDCODE = 32'h1000_0001,
    parameter int          USER_W = 8
) (
    input  logic              tck,
    input  logic              trst,
    input  logic              tms,
    input  logic              tdi,
    output logic              tdo,
    output logic              tdo_oe,
    output logic [3:0]        tap_state,
    output logic [IR_W-1:0]   ir_q
`ifdef JTAG_USERREG_EN
    ,
    output logic [USER_W-1:0] user_q,
    output logic              user_update
`endif
);

    if (IR_W < 2 || USER_W < 1 || IDCODE[0] != 1'b1) begin : g_param_check
        $error("jtag_tap: illegal parameter set");
    end

    tap_state_t      state;
    logic            tlr, capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir;
    logic [IR_W-1:0] ir_sr;
    logic [31:0]     id_sr;
    logic            bypass_sr;
    dr_sel_t         sel;
    logic            dr_lsb;
    logic            tdo_d;

    jtag_tap_fsm u_fsm (
        .tck        (tck),
        .trst       (trst),
        .tms        (tms),
        .state      (state),
        .tlr        (tlr),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .update_ir  (update_ir)
    );

    assign tap_state = state;

    // unrecognised opcodes fall through to BYPASS
    always_comb begin
        sel = SEL_BYPASS;
        if (ir_q == IR_W'(OP_IDCODE))
            sel = SEL_IDCODE;
`ifdef JTAG_USERREG_EN
        else if (ir_q == IR_W'(OP_USER))
            sel = SEL_USER;
`endif
    end

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            ir_sr <= '0;
            ir_q  <= IR_W'(OP_IDCODE);
        end else begin
            if (capture_ir)
                ir_sr <= IR_W'(IR_CAPTURE);
            else if (shift_ir)
                ir_sr <= {tdi, ir_sr[IR_W-1:1]};
            if (tlr)
                ir_q <= IR_W'(OP_IDCODE);
            else if (update_ir)
                ir_q <= ir_sr;
        end
    end

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            id_sr     <= '0;
            bypass_sr <= 1'b0;
        end else if (capture_dr) begin
            id_sr     <= IDCODE;
            bypass_sr <= 1'b0;
        end else if (shift_dr) begin
            if (sel == SEL_IDCODE)
                id_sr <= {tdi, id_sr[31:1]};
            else if (sel == SEL_BYPASS)
                bypass_sr <= tdi;
        end
    end

`ifdef JTAG_USERREG_EN
    logic [USER_W-1:0] user_sr;

    assign user_update = update_dr && (sel == SEL_USER);

    // concatenate-then-shift keeps USER_W == 1 legal
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            user_sr <= '0;
            user_q  <= '0;
        end else begin
            if (capture_dr && sel == SEL_USER)
                user_sr <= user_q;
            else if (shift_dr && sel == SEL_USER)
                user_sr <= USER_W'({tdi, user_sr} >> 1);
            if (user_update)
                user_q <= user_sr;
        end
    end
`else
    logic unused_update_dr;
    assign unused_update_dr = update_dr;
`endif

    always_comb begin
        dr_lsb = bypass_sr;
        case (sel)
            SEL_IDCODE: dr_lsb = id_sr[0];
`ifdef JTAG_USERREG_EN
            SEL_USER:   dr_lsb = user_sr[0];
`endif
            default:    dr_lsb = bypass_sr;
        endcase
        tdo_d = shift_ir ? ir_sr[0] : (shift_dr ? dr_lsb : 1'b0);
    end

    always_ff @(negedge tck or posedge trst) begin
        if (trst) begin
            tdo    <= 1'b0;
            tdo_oe <= 1'b0;
        end else begin
            tdo    <= tdo_d;
            tdo_oe <= shift_dr | shift_ir;
        end
    end

endmodule

// File: tb/tb_jtag_tap.sv
// tb/tb_jtag_tap.sv - scoreboard bench for jtag_tap (default and JTAG_USERREG_EN builds)
module tb_jtag_tap;

    localparam logic [31:0] ID = 32'h1000_0001;

    logic       tck = 1'b0;
    logic       trst = 1'b1;
    logic       tms = 1'b1;
    logic       tdi = 1'b0;
    logic       tdo, tdo_oe;
    logic [3:0] tap_state;
    logic [3:0] ir_q;
`ifdef JTAG_USERREG_EN
    logic [7:0] user_q;
    logic       user_update;
`endif

    int checks = 0;
    int fails = 0;
    int pulse_cnt = 0;
    bit exp_q[$];

    jtag_tap dut (
        .tck       (tck),
        .trst      (trst),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
        .tdo_oe    (tdo_oe),
        .tap_state (tap_state),
        .ir_q      (ir_q)
`ifdef JTAG_USERREG_EN
        ,
        .user_q      (user_q),
        .user_update (user_update)
`endif
    );

    always #5 tck = ~tck;

    // monitor: every rising edge with tdo_oe high presents one shifted-out bit
    always @(posedge tck) begin
        if (tdo_oe === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL tdo_unexpected: got tdo=%b, required no shift activity", tdo);
            end else begin
                bit e;
                e = exp_q.pop_front();
                if (tdo !== e) begin
                    fails++;
                    $display("FAIL tdo_bit: got %b required %b", tdo, e);
                end
            end
        end
    end

`ifdef JTAG_USERREG_EN
    always @(negedge tck) if (user_update === 1'b1) pulse_cnt++;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic step(input bit m, input bit d);
        @(negedge tck);
        tms = m;
        tdi = d;
        @(posedge tck);
        #1;
    endtask

    task automatic shift_bit(input bit m, input bit d, input bit e);
        @(negedge tck);
        tms = m;
        tdi = d;
        exp_q.push_back(e);
        @(posedge tck);
        #1;
    endtask

    task automatic shift_bits(input int n, input logic [31:0] din, input logic [31:0] dexp, input bit last_exit);
        for (int i = 0; i < n; i++)
            shift_bit(last_exit && (i == n - 1), din[i], dexp[i]);
    endtask

    task automatic goto_shdr();
        step(1, 0); step(0, 0); step(0, 0);
    endtask

    task automatic goto_shir();
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    endtask

    task automatic exit_update();
        step(1, 0); step(0, 0);
    endtask

    task automatic load_ir(input logic [3:0] v);
        goto_shir();
        shift_bits(4, {28'd0, v}, 32'h1, 1'b1);
        exit_update();
    endtask

    initial begin
        #22;
        check("reset_state", tap_state, 4'hF);
        check("reset_ir", ir_q, 4'h1);
        check("reset_tdo", tdo, 1'b0);
        check("reset_tdo_oe", tdo_oe, 1'b0);
`ifdef JTAG_USERREG_EN
        check("reset_user_q", user_q, 8'h00);
`endif
        @(negedge tck);
        trst = 1'b0;
        step(0, 0);
        check("rti_after_reset", tap_state, 4'hC);

        goto_shdr();
        check("in_shift_dr", tap_state, 4'h2);
        shift_bits(32, 32'h0, ID, 1'b1);
        exit_update();
        check("idcode_back_rti", tap_state, 4'hC);

        load_ir(4'hF);
        check("ir_bypass", ir_q, 4'hF);
        goto_shdr();
        shift_bits(4, 32'b1101, 32'b1010, 1'b1);
        exit_update();

        load_ir(4'h1);
        check("ir_idcode", ir_q, 4'h1);
        goto_shdr();
        shift_bits(8, 32'h0, ID, 1'b1);
        step(0, 0);
        check("pause_dr", tap_state, 4'h3);
        check("pause_tdo_oe", tdo_oe, 1'b0);
        check("pause_tdo", tdo, 1'b0);
        step(0, 0);
        step(1, 0);
        check("exit2_dr", tap_state, 4'h0);
        step(0, 0);
        shift_bits(24, 32'h0, ID >> 8, 1'b1);
        exit_update();

        load_ir(4'hF);
        goto_shir();
        shift_bits(2, 32'h0, 32'h1, 1'b0);
        shift_bit(1, 0, 1'b0);
        step(1, 0); step(1, 0); step(1, 0); step(1, 0);
        check("tms5_tlr", tap_state, 4'hF);
        step(1, 0);
        check("tlr_forces_idcode", ir_q, 4'h1);
        step(0, 0);

        goto_shdr();
        shift_bits(3, 32'h0, ID, 1'b0);
        #2;
        trst = 1'b1;
        #1;
        check("trst_tdo", tdo, 1'b0);
        check("trst_tdo_oe", tdo_oe, 1'b0);
        check("trst_state", tap_state, 4'hF);
`ifdef JTAG_USERREG_EN
        check("trst_user_q", user_q, 8'h00);
        check("trst_no_update", pulse_cnt, 0);
`endif
        repeat (2) @(negedge tck);
        check("trst_hold_oe", tdo_oe, 1'b0);
        trst = 1'b0;
        step(0, 0);
        check("rti_after_trst", tap_state, 4'hC);

`ifdef JTAG_USERREG_EN
        load_ir(4'h2);
        check("ir_user", ir_q, 4'h2);
        goto_shdr();
        shift_bits(8, 32'hA5, 32'h0, 1'b1);
        step(1, 0);
        check("user_update_high", user_update, 1'b1);
        step(0, 0);
        check("user_update_low", user_update, 1'b0);
        check("user_q_a5", user_q, 8'hA5);
        goto_shdr();
        shift_bits(8, 32'hA5, 32'hA5, 1'b1);
        exit_update();
        check("user_q_kept", user_q, 8'hA5);
        check("user_pulses", pulse_cnt, 2);
`endif

        repeat (2) @(negedge tck);
        check("scoreboard_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
